multicycle_controller: RTL

- Main sequencing FSM for the multicycle version of the CPU datapath.
- Takes op/funct/rd/cond from the instruction register and drives all datapath mux selects, write enables and ALU control, one microstep per cycle.
- Holds the NZCV flags register and the condition-execute decision.
- Waits on a memory ready handshake for instruction fetch, load and store.

---
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, memory handshake and datapath controls of the multicycle controller
interface multicycle_controller_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_w;
  logic       reg_w;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [1:0] alu_control;
  logic       shift_flag;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;
  modport master (
    input  op, funct, rd, cond, alu_flags, mem_ready,
    output pc_write, adr_src, ir_write, mem_w, reg_w, alu_src_a, alu_src_b,
           result_src, imm_src, reg_src, alu_control, shift_flag, instr_done,
           illegal, state
  );
  modport slave (
    output op, funct, rd, cond, alu_flags, mem_ready,
    input  pc_write, adr_src, ir_write, mem_w, reg_w, alu_src_a, alu_src_b,
           result_src, imm_src, reg_src, alu_control, shift_flag, instr_done,
           illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM, NZCV flags and condition-execute decision for the multicycle CPU
module multicycle_controller #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
                         MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9;
  logic [3:0] r_state, w_next, r_flags, w_cmd;
  logic       r_cond_ex, w_cond_ok, w_alu_st, w_no_write, w_alu_wr;
  logic [1:0] w_alu_ctl;
  logic       w_pc_write, w_ir_write, w_mem_w, w_reg_w, w_done, w_illegal;
  assign w_cmd      = bus.funct[4:1];
  assign w_alu_st   = (r_state == EXECUTER) || (r_state == EXECUTEI);
  assign w_no_write = (w_cmd == 4'b1010) || (w_cmd == 4'b1000) || (w_cmd == 4'b1011);
  assign w_alu_wr   = r_cond_ex & ~w_no_write;
  always_comb begin
    w_cond_ok = 1'b0;
    case (bus.cond)
      4'b0000: w_cond_ok = r_flags[2];
      4'b0001: w_cond_ok = ~r_flags[2];
      4'b0010: w_cond_ok = r_flags[1];
      4'b0011: w_cond_ok = ~r_flags[1];
      4'b0100: w_cond_ok = r_flags[3];
      4'b0101: w_cond_ok = ~r_flags[3];
      4'b0110: w_cond_ok = r_flags[0];
      4'b0111: w_cond_ok = ~r_flags[0];
      4'b1000: w_cond_ok = r_flags[1] & ~r_flags[2];
      4'b1001: w_cond_ok = ~r_flags[1] | r_flags[2];
      4'b1010: w_cond_ok = r_flags[3] == r_flags[0];
      4'b1011: w_cond_ok = r_flags[3] != r_flags[0];
      4'b1100: w_cond_ok = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_cond_ok = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end
  always_comb begin
    w_alu_ctl = 2'b00;
    case (w_cmd)
      4'b0010, 4'b1010: w_alu_ctl = 2'b01;
      4'b0000, 4'b1000: w_alu_ctl = 2'b10;
      4'b1100:          w_alu_ctl = 2'b11;
      default:          w_alu_ctl = 2'b00;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else r_state <= w_next;
  end
  // Logical ops leave C and V untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags   <= RESET_FLAGS;
      r_cond_ex <= 1'b0;
    end else begin
      if (r_state == DECODE) r_cond_ex <= w_cond_ok;
      if (w_alu_st && r_cond_ex && bus.funct[0]) begin
        r_flags[3:2] <= bus.alu_flags[3:2];
        if (!w_alu_ctl[1]) r_flags[1:0] <= bus.alu_flags[1:0];
      end
    end
  end
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = bus.mem_ready ? DECODE : FETCH;
      DECODE:   w_next = (bus.op == 2'b01) ? MEMADR :
                         (bus.op == 2'b10) ? BRANCH :
                         (bus.op == 2'b00) ? (bus.funct[5] ? EXECUTEI : EXECUTER) : FETCH;
      MEMADR:   w_next = bus.funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: w_next = (bus.mem_ready || !r_cond_ex) ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI: w_next = ALUWB;
      default:  w_next = FETCH;
    endcase
  end
  always_comb begin
    w_pc_write = 1'b0;
    w_ir_write = 1'b0;
    w_mem_w    = 1'b0;
    w_reg_w    = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.result_src = 2'b00;
    bus.imm_src    = 2'b00;
    bus.reg_src    = 2'b00;
    case (r_state)
      FETCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        w_ir_write     = bus.mem_ready;
        w_pc_write     = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.reg_src    = 2'b01;
        w_illegal      = bus.op == 2'b11;
        w_done         = bus.op == 2'b11;
      end
      MEMADR: begin
        bus.alu_src_b = 2'b01;
        bus.imm_src   = 2'b01;
        bus.reg_src   = 2'b10;
      end
      MEMREAD: bus.adr_src = 1'b1;
      MEMWB: begin
        bus.result_src = 2'b01;
        w_reg_w        = r_cond_ex;
        w_pc_write     = r_cond_ex & (bus.rd == 4'd15);
        w_done         = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src = 1'b1;
        w_mem_w     = r_cond_ex;
        w_done      = bus.mem_ready | ~r_cond_ex;
      end
      EXECUTEI: bus.alu_src_b = 2'b01;
      ALUWB: begin
        w_reg_w    = w_alu_wr;
        w_pc_write = w_alu_wr & (bus.rd == 4'd15);
        w_done     = 1'b1;
      end
      BRANCH: begin
        bus.reg_src    = 2'b01;
        bus.alu_src_b  = 2'b01;
        bus.imm_src    = 2'b10;
        bus.result_src = 2'b10;
        w_pc_write     = r_cond_ex;
        w_done         = 1'b1;
      end
      default: ;
    endcase
  end
  assign bus.pc_write    = w_pc_write & ~reset;
  assign bus.ir_write    = w_ir_write & ~reset;
  assign bus.mem_w       = w_mem_w & ~reset;
  assign bus.reg_w       = w_reg_w & ~reset;
  assign bus.instr_done  = w_done & ~reset;
  assign bus.illegal     = w_illegal & ~reset;
  assign bus.alu_control = w_alu_st ? w_alu_ctl : 2'b00;
  assign bus.shift_flag  = w_alu_st & (w_cmd == 4'b1101);
  assign bus.state       = r_state;
endmodule
